// File: rtl/booth_product_bcd_if.sv
// Request/result bundle between the Booth multiplier control and the BCD converter.
// The multiplier side owns start/product, and the converter side owns the result signals.
interface booth_product_bcd_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      product;
  logic                  busy;
  logic                  done;
  logic                  valid;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;

  modport master (
    output start, product,
    input  busy, done, valid, sign, bcd
  );

  modport slave (
    input  start, product,
    output busy, done, valid, sign, bcd
  );
endinterface

// File: rtl/booth_product_bcd.sv
// Signed product to packed-BCD converter using iterative double dabble.
// Each bit is handled in two cycles: one to add 3 to the nibbles, then one to shift.
module booth_product_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_product_bcd_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, FINISH} state_t;

  state_t            state_reg;
  logic              sign_r_reg;
  logic [WIDTH-1:0]  mag_reg;
  logic [BW-1:0]     work_reg;
  logic [CW-1:0]     cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              valid_reg;
  logic              sign_reg;
  logic [BW-1:0]     bcd_reg;

  logic [WIDTH-1:0]  mag_in;
  logic [BW-1:0]     work_adj;

  // Taking the magnitude in WIDTH unsigned bits lets the most negative value map to itself (0x8000 -> 32768).
  assign mag_in = bus.product[WIDTH-1] ? (~bus.product + WIDTH'(1)) : bus.product;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign work_adj[gi*4 +: 4] = (work_reg[gi*4 +: 4] >= 4'd5) ?
                                   (work_reg[gi*4 +: 4] + 4'd3) :
                                   work_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sign_r_reg <= 1'b0;
      mag_reg    <= '0;
      work_reg   <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      valid_reg  <= 1'b0;
      sign_reg   <= 1'b0;
      bcd_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sign_r_reg <= bus.product[WIDTH-1];
            mag_reg    <= mag_in;
            work_reg   <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            valid_reg  <= 1'b0;
            state_reg  <= ADJUST;
          end
        end
        ADJUST: begin
          work_reg  <= work_adj;
          state_reg <= SHIFT;
        end
        SHIFT: begin
          {work_reg, mag_reg} <= {work_reg, mag_reg} << 1;
          cnt_reg             <= cnt_reg + CW'(1);
          state_reg           <= (cnt_reg == CW'(WIDTH - 1)) ? FINISH : ADJUST;
        end
        FINISH: begin
          bcd_reg   <= work_reg;
          sign_reg  <= sign_r_reg;
          done_reg  <= 1'b1;
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;
  assign bus.valid = valid_reg;
  assign bus.sign  = sign_reg;
  assign bus.bcd   = bcd_reg;
endmodule

// File: doc/booth_product_bcd.md
Name: booth_product_bcd

Overview:
- Sequential signed-binary to BCD converter sitting directly downstream of the Booth multiplier datapath and control.
- Accepts the signed product when the multiplier signals completion, then converts its magnitude to packed BCD using iterative shift-add-3 (double dabble).
- Presents a sign flag and decimal digits to the display driver.
- One conversion at a time; new requests are refused while busy.

Parameters:
- WIDTH, 16, product width in bits, two's complement.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^(WIDTH-1); 5 covers 32768.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  conversion request; tied to the multiplier done pulse; sampled only in IDLE.
- product  input  WIDTH  signed product, sampled on the edge that accepts start.
- busy  output  1  high from the accept edge until DONE completes.
- done  output  1  one-cycle pulse when bcd/sign update.
- valid  output  1  level; high once a result is present, cleared on next accepted start.
- sign  output  1  1 = product was negative.
- bcd  output  4*DIGITS  packed BCD magnitude, most significant digit in top nibble.

Behaviour:
- Reset: all registers and outputs are 0 (busy, done, valid, sign, bcd, internal shift/count regs); state=IDLE. Reset wins over every other event.
- Reset mid-conversion: abort, return to IDLE, all outputs 0. No done pulse is issued.
- Clock domain: single, clk only. Internal state is one-hot or enum; encoding is free.
- States: IDLE, ADJUST, SHIFT, FINISH.
- IDLE:
  - If start=1 at an edge, accept the request:
    - sign_r <= product[WIDTH-1].
    - mag <= |product|, computed in WIDTH bits as unsigned (0x8000 -> 0x8000, i.e. 32768).
    - work BCD <= 0; cnt <= 0; busy <= 1; valid <= 0.
    - Next state = ADJUST.
  - Otherwise remain in IDLE.
- ADJUST: for each of the DIGITS nibbles of work BCD, if nibble >= 5 then nibble += 3, all in parallel. Next state = SHIFT.
- SHIFT:
  - Shift {work BCD, mag} left by 1 as one concatenated register.
  - cnt <= cnt + 1.
  - If cnt == WIDTH-1 (before increment), go to FINISH; otherwise go to ADJUST.
- FINISH:
  - bcd <= work BCD; sign <= sign_r.
  - done <= 1 for exactly one cycle; valid <= 1; busy <= 0.
  - Next state = IDLE.
- cnt width: $clog2(WIDTH)+1 bits, no wrap within a conversion.
- Latency: accept edge at cycle 0; done/valid/bcd visible after edge 2*WIDTH+1, which is cycle 33 for WIDTH=16. Throughput is one conversion per 2*WIDTH+2 cycles minimum.
- Back-to-back:
  - start high on the same edge that leaves FINISH is not accepted, because state is FINISH, not IDLE.
  - start must be high in an IDLE cycle to be accepted.
- start while busy: ignored. No queueing, no effect on the in-flight result, product not sampled.
- start held high continuously: a new conversion is accepted on each IDLE cycle. valid therefore drops on the accept edge, one cycle after done.
- Output stability:
  - bcd and sign change only in FINISH, or to 0 on reset.
  - They hold their last value through subsequent conversions until the next FINISH.
- Zero: product 0 gives sign=0 and bcd all zeros. Negative zero cannot occur.
- Each output nibble is always in the range 0..9. A nibble above 9 is a design error, and the bench asserts on it whenever valid=1.

Test Plan:
- Positive value: rst for 2 cycles, then start pulse with product=16'h3039 (12345).
  - Required: done exactly 33 cycles after the accept edge.
  - Required: bcd=20'h12345, sign=0, valid=1, busy low after done.
- Negative values:
  - product=16'hFFFF gives bcd=20'h00001, sign=1.
  - product=16'h8000 gives bcd=20'h32768, sign=1.
  - product=16'hCFC7 (-12345) gives bcd=20'h12345, sign=1.
- Boundary values:
  - product=16'h0000 gives bcd=0, sign=0.
  - product=16'h7FFF gives bcd=20'h32767, sign=0.
  - Each case produces exactly one done pulse.
- Busy rejection: start with 16'h0064 (100), then start again at cycle 10 with 16'h0001.
  - Required: the second start is ignored; result bcd=20'h00100.
  - Required: a single done pulse; busy held continuously from cycle 0 to cycle 33.
- Reset mid-op: start with 16'h1234, assert rst at cycle 15 for 1 cycle.
  - Required: all outputs 0 the next cycle; no done pulse.
  - Required: a fresh start with 16'h0007 then gives bcd=20'h00007 after 33 cycles.
- Result hold and valid clear: after the 12345 result, start with 16'hFFFE.
  - Required: valid drops on the accept edge; bcd stays 20'h12345 until the new done.
  - Required: then bcd=20'h00002, sign=1.
